riscv_test_monitor: RTL and testbench

//  Synthesizable, parametrised self-check monitor for the RISCV_TOP core.

---
 rtl/riscv_test_monitor.sv | 132 +++++++++++++
 tb/tb_riscv_test_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// Checkpoint monitor for RISCV_TOP: compares OUTPUT_PORT against a loadable table
// of (instruction count, expected value) pairs and reports pass/fail/timeout.
module riscv_test_monitor #(
    parameter int NUM_TEST     = 32,
    parameter int TIDX_W       = 5,
    parameter int DWIDTH       = 32,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 1000000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              CLR,
    input  logic              TBL_WE,
    input  logic [TIDX_W-1:0] TBL_WADDR,
    input  logic [CNT_W-1:0]  TBL_NUM_INST,
    input  logic [DWIDTH-1:0] TBL_ANS,
    input  logic [CNT_W-1:0]  NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic [2:0]        STATE,
    output logic              DONE,
    output logic [TIDX_W:0]   PASS_CNT,
    output logic [TIDX_W:0]   FAIL_CNT,
    output logic [TIDX_W-1:0] FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_GOT,
    output logic [CNT_W-1:0]  CYCLE_CNT
);
    localparam int PW = TIDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  tbl_ni  [NUM_TEST];
    logic [DWIDTH-1:0] tbl_ans [NUM_TEST];
    logic [PW-1:0]     ptr, tbl_len;

    logic [CNT_W-1:0]  cur_ni;
    logic [DWIDTH-1:0] cur_ans;
    logic              have_entry, consume, match, fail_now, timeout, halt_ok;
    logic [PW-1:0]     ptr_nxt, fail_cnt_nxt, waddr_p1;
    logic              wr_ok;

    always_comb begin
        cur_ni       = tbl_ni[ptr[TIDX_W-1:0]];
        cur_ans      = tbl_ans[ptr[TIDX_W-1:0]];
        have_entry   = ptr < tbl_len;
        consume      = have_entry && (NUM_INST >= cur_ni);
        match        = have_entry && (NUM_INST == cur_ni) && (OUTPUT_PORT == cur_ans);
        fail_now     = consume && !match;
        ptr_nxt      = ptr + PW'(consume);
        fail_cnt_nxt = (fail_now && FAIL_CNT != '1) ? FAIL_CNT + PW'(1) : FAIL_CNT;
        timeout      = CYCLE_CNT == CNT_W'(TIMEOUT - 1);
        halt_ok      = (fail_cnt_nxt == '0) && (ptr_nxt == tbl_len);
        wr_ok        = (state == S_IDLE) && TBL_WE && ({1'b0, TBL_WADDR} < PW'(NUM_TEST));
        waddr_p1     = {1'b0, TBL_WADDR} + PW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (START) state_nxt = S_RUN;
            S_RUN: begin
                if (fail_now && STOP_ON_FAIL != 0) state_nxt = S_FAIL;
                else if (HALT)                     state_nxt = halt_ok ? S_PASS : S_FAIL;
                else if (timeout)                  state_nxt = S_TOUT;
            end
            S_PASS, S_FAIL, S_TOUT: if (CLR) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Table storage is deliberately left out of reset so a reset keeps the RAM contents.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            tbl_ni[TBL_WADDR]  <= TBL_NUM_INST;
            tbl_ans[TBL_WADDR] <= TBL_ANS;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr       <= '0;
            tbl_len   <= '0;
            PASS_CNT  <= '0;
            FAIL_CNT  <= '0;
            FAIL_IDX  <= '0;
            FAIL_GOT  <= '0;
            CYCLE_CNT <= '0;
        end else if (state == S_IDLE) begin
            if (wr_ok && waddr_p1 > tbl_len) tbl_len <= waddr_p1;
            if (START) begin
                ptr       <= '0;
                PASS_CNT  <= '0;
                FAIL_CNT  <= '0;
                FAIL_IDX  <= '0;
                FAIL_GOT  <= '0;
                CYCLE_CNT <= '0;
            end
        end else if (state == S_RUN) begin
            ptr      <= ptr_nxt;
            FAIL_CNT <= fail_cnt_nxt;
            if (match && PASS_CNT != '1) PASS_CNT <= PASS_CNT + PW'(1);
            if (!timeout && CYCLE_CNT != '1) CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
            // First failure wins; unchecked entries at HALT count as a failure point too.
            if (fail_now && FAIL_CNT == '0) begin
                FAIL_IDX <= ptr[TIDX_W-1:0];
                FAIL_GOT <= OUTPUT_PORT;
            end else if (HALT && fail_cnt_nxt == '0 && ptr_nxt != tbl_len) begin
                FAIL_IDX <= ptr_nxt[TIDX_W-1:0];
                FAIL_GOT <= OUTPUT_PORT;
            end
        end
    end

    assign STATE = state;
    assign DONE  = (state == S_PASS) || (state == S_FAIL) || (state == S_TOUT);

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: one instance stops on first fail (short timeout),
// the other keeps counting failures.
module tb_riscv_test_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, clr = 1'b0, tbl_we = 1'b0, halt = 1'b0;
    logic [4:0]  tbl_waddr = '0;
    logic [31:0] tbl_ni = '0, tbl_ans = '0, num_inst = '0, out_port = '0;

    logic [2:0]  a_state, b_state;
    logic        a_done, b_done;
    logic [5:0]  a_pass, a_fail, b_pass, b_fail;
    logic [4:0]  a_idx, b_idx;
    logic [31:0] a_got, b_got, a_cyc, b_cyc;

    int checks = 0;
    int failures = 0;

    riscv_test_monitor #(.TIMEOUT(16), .STOP_ON_FAIL(1)) dut_a (
        .CLK(clk), .RST(rst), .START(start), .CLR(clr), .TBL_WE(tbl_we),
        .TBL_WADDR(tbl_waddr), .TBL_NUM_INST(tbl_ni), .TBL_ANS(tbl_ans),
        .NUM_INST(num_inst), .OUTPUT_PORT(out_port), .HALT(halt),
        .STATE(a_state), .DONE(a_done), .PASS_CNT(a_pass), .FAIL_CNT(a_fail),
        .FAIL_IDX(a_idx), .FAIL_GOT(a_got), .CYCLE_CNT(a_cyc));

    riscv_test_monitor #(.TIMEOUT(64), .STOP_ON_FAIL(0)) dut_b (
        .CLK(clk), .RST(rst), .START(start), .CLR(clr), .TBL_WE(tbl_we),
        .TBL_WADDR(tbl_waddr), .TBL_NUM_INST(tbl_ni), .TBL_ANS(tbl_ans),
        .NUM_INST(num_inst), .OUTPUT_PORT(out_port), .HALT(halt),
        .STATE(b_state), .DONE(b_done), .PASS_CNT(b_pass), .FAIL_CNT(b_fail),
        .FAIL_IDX(b_idx), .FAIL_GOT(b_got), .CYCLE_CNT(b_cyc));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] ni, input logic [31:0] ans);
        tbl_we = 1'b1; tbl_waddr = a; tbl_ni = ni; tbl_ans = ans;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic load();
        wr(5'd0, 32'd1, 32'd0);
        wr(5'd1, 32'd3, 32'd5);
        wr(5'd2, 32'd8, 32'd5);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic step(input int n, input logic [31:0] port, input logic h);
        num_inst = n; out_port = port; halt = h;
        tick();
        halt = 1'b0;
    endtask

    function automatic logic [31:0] good_port(input int n);
        return (n >= 3) ? 32'd5 : 32'd0;
    endfunction

    task automatic run_t1();
        for (int n = 0; n <= 8; n++) begin
            if (n == 2) begin
                tbl_we = 1'b1; tbl_waddr = 5'd3; tbl_ni = 32'd5; tbl_ans = 32'd99;
            end
            step(n, good_port(n), n == 8);
            tbl_we = 1'b0;
        end
    endtask

    initial begin
        #12 rst = 1'b0;
        chk("reset_state", {29'd0, a_state}, 32'd0);
        chk("reset_done", {31'd0, a_done}, 32'd0);
        chk("reset_cyc", a_cyc, 32'd0);

        // T1: clean run, RUN-time table write must be ignored
        load();
        go();
        chk("t1_run", {29'd0, a_state}, 32'd1);
        run_t1();
        chk("t1_a_state", {29'd0, a_state}, 32'd2);
        chk("t1_a_done", {31'd0, a_done}, 32'd1);
        chk("t1_a_pass", {26'd0, a_pass}, 32'd3);
        chk("t1_a_fail", {26'd0, a_fail}, 32'd0);
        chk("t1_a_cyc", a_cyc, 32'd9);
        chk("t1_b_state", {29'd0, b_state}, 32'd2);
        start = 1'b1;
        step(20, 32'd7, 1'b0);
        start = 1'b0;
        chk("t1_frozen_state", {29'd0, a_state}, 32'd2);
        chk("t1_frozen_cyc", a_cyc, 32'd9);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t1_clr_state", {29'd0, a_state}, 32'd0);
        chk("t1_clr_pass_held", {26'd0, a_pass}, 32'd3);

        // T2: wrong port at checkpoint 1
        do_reset(); load(); go();
        for (int n = 0; n <= 3; n++) step(n, (n == 3) ? 32'd6 : good_port(n), 1'b0);
        chk("t2_a_state", {29'd0, a_state}, 32'd3);
        chk("t2_a_idx", {27'd0, a_idx}, 32'd1);
        chk("t2_a_got", a_got, 32'd6);
        chk("t2_a_pass", {26'd0, a_pass}, 32'd1);
        chk("t2_a_fail", {26'd0, a_fail}, 32'd1);
        chk("t2_b_running", {29'd0, b_state}, 32'd1);

        // T3: checkpoint 3 skipped, non-stopping instance keeps checking
        do_reset(); load(); go();
        for (int n = 0; n <= 8; n++) if (n != 3) step(n, good_port(n), n == 8);
        chk("t3_b_state", {29'd0, b_state}, 32'd3);
        chk("t3_b_fail", {26'd0, b_fail}, 32'd1);
        chk("t3_b_idx", {27'd0, b_idx}, 32'd1);
        chk("t3_b_pass", {26'd0, b_pass}, 32'd2);
        chk("t3_b_got", b_got, 32'd5);
        chk("t3_a_state", {29'd0, a_state}, 32'd3);
        chk("t3_a_pass", {26'd0, a_pass}, 32'd1);

        // T4: timeout after 16 RUN cycles
        do_reset(); go();
        for (int i = 0; i < 15; i++) step(0, 32'd0, 1'b0);
        chk("t4_pre_state", {29'd0, a_state}, 32'd1);
        chk("t4_pre_cyc", a_cyc, 32'd15);
        step(0, 32'd0, 1'b0);
        chk("t4_state", {29'd0, a_state}, 32'd4);
        chk("t4_cyc", a_cyc, 32'd15);
        chk("t4_b_cyc", b_cyc, 32'd16);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("t4_clr", {29'd0, a_state}, 32'd0);
        chk("t4_clr_cyc_held", a_cyc, 32'd15);

        // T5: HALT with entry (8,5) still pending
        do_reset(); load(); go();
        for (int n = 0; n <= 3; n++) step(n, good_port(n), n == 3);
        chk("t5_b_state", {29'd0, b_state}, 32'd3);
        chk("t5_b_idx", {27'd0, b_idx}, 32'd2);
        chk("t5_b_fail", {26'd0, b_fail}, 32'd0);
        chk("t5_b_pass", {26'd0, b_pass}, 32'd2);
        chk("t5_a_state", {29'd0, a_state}, 32'd3);

        // T6: async reset mid-run, then a full clean run
        do_reset(); load(); go();
        for (int n = 0; n <= 4; n++) step(n, good_port(n), 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_state", {29'd0, a_state}, 32'd0);
        chk("t6_rst_pass", {26'd0, a_pass}, 32'd0);
        chk("t6_rst_cyc", a_cyc, 32'd0);
        #1 rst = 1'b0;
        load(); go();
        run_t1();
        chk("t6_state", {29'd0, a_state}, 32'd2);
        chk("t6_pass", {26'd0, a_pass}, 32'd3);

        // Empty table: first HALT passes
        do_reset(); go();
        step(0, 32'd0, 1'b1);
        chk("t7_empty_a", {29'd0, a_state}, 32'd2);
        chk("t7_empty_b", {29'd0, b_state}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
